game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Frame-level game sequencer for the tank/eagle playfield. Consumes hit and kill events from the eagle, player-tank and enemy blocks. Runs the round state machine: idle, play, respawn delay, eagle-destroyed blink, game over and victory. Drives the enables and visibility flags those blocks and the VGA pixel mux obey, and keeps the lives and enemies-remaining counters.

## Interface
Parameters:
- `LIVES`, 3: player lives loaded at round start (1..3).
- `ENEMY_COUNT`, 20: enemies to destroy for victory (1..255).
- `RESPAWN_FRAMES`, 60: frames the player tank stays hidden after being hit (1..255).
- `BLINK_FRAMES`, 90: frames of eagle blink before game over (1..255).
- `BLINK_BIT`, 3: `frame_cnt` bit that drives the eagle blink (0..7).

Ports:
- `clk_50MHz` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `refresh_tick` in 1: one-cycle pulse per video frame.
- `start_btn` in 1: start button level, already synchronized.
- `eagle_hit` in 1: eagle destroyed; level, sticky until reset.
- `tank_hit` in 1: one-cycle pulse, player tank hit.
- `enemy_killed` in 1: one-cycle pulse, enemy destroyed.
- `state_o` out 3: current state.
- `play_en` out 1: movement and firing enable for all tanks.
- `tank_visible` out 1: player tank sprite enable.
- `eagle_visible` out 1: eagle sprite enable.
- `respawn_pulse` out 1: one cycle; player tank reloads its start position.
- `round_start` out 1: one cycle; all units reload start positions.
- `lives` out 2: remaining lives.
- `enemies_left` out 8: remaining enemies.
- `game_over` out 1: high in GAME_OVER.
- `victory` out 1: high in VICTORY.

## Operation
- States and encodings: IDLE=0, PLAY=1, RESPAWN=2, EAGLE_FALL=3, GAME_OVER=4, VICTORY=5. Codes 6 and 7 recover to IDLE on the next clock.
- `start_rise` = `start_btn & ~start_q`, where `start_q` is `start_btn` registered once.
- IDLE:
  - On `start_rise`, go to PLAY.
  - Load `lives`=LIVES and `enemies_left`=ENEMY_COUNT.
  - Pulse `round_start`.
- PLAY: events are handled with priority `eagle_hit` > `tank_hit` > `enemy_killed`. Only the highest-priority event present in a cycle is acted on; lower ones in that cycle are dropped.
  - `eagle_hit`: go to EAGLE_FALL, `frame_cnt`=BLINK_FRAMES.
  - `tank_hit` with `lives`==1: set `lives`=0 and go to GAME_OVER.
  - `tank_hit` with `lives`>1: decrement `lives`, go to RESPAWN, `frame_cnt`=RESPAWN_FRAMES.
  - `enemy_killed` with `enemies_left`==1: set it to 0 and go to VICTORY.
  - `enemy_killed` otherwise: decrement `enemies_left`.
- RESPAWN:
  - `frame_cnt` decrements on each `refresh_tick`.
  - When a tick arrives with `frame_cnt`==1: go to PLAY and pulse `respawn_pulse`.
  - `eagle_hit` goes to EAGLE_FALL; it has priority over the tick.
  - `enemy_killed` is still counted (bullets in flight). Reaching 0 goes to VICTORY.
  - `tank_hit` is ignored.
- EAGLE_FALL:
  - All events are ignored.
  - `frame_cnt` decrements per tick; a tick with `frame_cnt`==1 goes to GAME_OVER.
- GAME_OVER / VICTORY: `start_rise` goes to IDLE. Counters hold their final values.
- Outputs by state:
  - `play_en`=1 only in PLAY.
  - `tank_visible`=1 in PLAY and EAGLE_FALL.
  - `eagle_visible`=`frame_cnt[BLINK_BIT]` in EAGLE_FALL, 0 in GAME_OVER, 1 otherwise.
  - `game_over` and `victory` decode the state.
- Arithmetic:
  - `frame_cnt` is 8-bit unsigned. `lives` and `enemies_left` never wrap below 0.
  - `eagle_hit` is level: it is acted on in any PLAY/RESPAWN cycle where it is high, including the first cycle after entering PLAY.

## Timing
- All outputs are registered. Every output reflects the state and counters after the clock edge that sampled the event; latency is 1 cycle from event to output.
- Pulse outputs (`round_start`, `respawn_pulse`) are high for exactly the cycle following the transition edge.
- Reset values: state IDLE, `frame_cnt`=0, `start_q`=0, `lives`=0, `enemies_left`=0.
- Output values under reset: `play_en`=0, `tank_visible`=0, `eagle_visible`=1, all pulses 0, `game_over`=0, `victory`=0.
- Reset asserted mid-operation returns to IDLE immediately (asynchronous) regardless of state.
- `start_btn` already high when reset releases produces no `start_rise` until it goes low then high again.
- A `refresh_tick` coinciding with an event in RESPAWN: the event is handled and the counter is not decremented in that cycle.

## Structure
- Shared package `tank_game_pkg` holds:
  - the state enum (3-bit) with the encodings above;
  - the `LIVES_W`=2 and `ENEMY_W`=8 constants.
- Single module; no sub-module is required. The frame down-counter stays inline (about 10 lines).

## Test plan
- Reset, then `start_btn` 0→1 → `state_o`=1, `lives`=3, `enemies_left`=20, `round_start` high 1 cycle, `play_en`=1.
- In PLAY, pulse `tank_hit` → `state_o`=2, `lives`=2, `tank_visible`=0. After 60 ticks → `state_o`=1 and `respawn_pulse` for 1 cycle.
- Third `tank_hit` (`lives`=1) → `state_o`=4, `lives`=0, `game_over`=1, `play_en`=0.
- Assert `eagle_hit`, `tank_hit` and `enemy_killed` in the same cycle in PLAY → `state_o`=3 with counters unchanged. `eagle_visible` toggles every 8 ticks; after 90 ticks → `state_o`=4 and `eagle_visible`=0.
- ENEMY_COUNT=2: two `enemy_killed` pulses → `enemies_left`=0, `state_o`=5, `victory`=1. Then `start_rise` → `state_o`=0.
- Assert `reset` during RESPAWN with `frame_cnt`=30 → `state_o`=0 immediately. After release, `start_btn` held high produces no transition.

Source files
------------

// File: rtl/tank_game_pkg.sv
// Shared types and widths for the tank/eagle game blocks.
//   game_state_e : round state machine encoding (3-bit, codes 6/7 unused)
//   LIVES_W      : width of the player lives counter
//   ENEMY_W      : width of the enemies-remaining counter
//   FRAME_W      : width of the frame down-counter
package tank_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_RESPAWN    = 3'd2,
        ST_EAGLE_FALL = 3'd3,
        ST_GAME_OVER  = 3'd4,
        ST_VICTORY    = 3'd5
    } game_state_e;

    localparam int LIVES_W = 2;
    localparam int ENEMY_W = 8;
    localparam int FRAME_W = 8;

endpackage

// File: rtl/game_flow_ctrl.sv
// Frame-level game sequencer for the tank/eagle playfield.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a start press; counters hold last round values
// PLAY  | round running, all tanks may move and fire
// RESP  | player tank hidden for RESPAWN_FRAMES after losing a life
// EFALL | eagle destroyed, eagle blinks for BLINK_FRAMES frames
// GOVER | game lost, counters frozen until start press
// VICT  | all enemies destroyed, counters frozen until start press
//
// Ports:
//   clk_50MHz, reset (async active-high)
//   refresh_tick  : one pulse per video frame
//   start_btn     : synchronized start button level
//   eagle_hit     : sticky eagle-destroyed level
//   tank_hit      : player tank hit pulse
//   enemy_killed  : enemy destroyed pulse
//   state_o       : current state code
//   play_en, tank_visible, eagle_visible : unit / sprite enables
//   respawn_pulse, round_start           : one-cycle reload pulses
//   lives, enemies_left                  : round counters
//   game_over, victory                   : terminal state flags
module game_flow_ctrl
    import tank_game_pkg::*;
#(
    parameter int LIVES          = 3,
    parameter int ENEMY_COUNT    = 20,
    parameter int RESPAWN_FRAMES = 60,
    parameter int BLINK_FRAMES   = 90,
    parameter int BLINK_BIT      = 3
) (
    input  logic               clk_50MHz,
    input  logic               reset,
    input  logic               refresh_tick,
    input  logic               start_btn,
    input  logic               eagle_hit,
    input  logic               tank_hit,
    input  logic               enemy_killed,
    output logic [2:0]         state_o,
    output logic               play_en,
    output logic               tank_visible,
    output logic               eagle_visible,
    output logic               respawn_pulse,
    output logic               round_start,
    output logic [LIVES_W-1:0] lives,
    output logic [ENEMY_W-1:0] enemies_left,
    output logic               game_over,
    output logic               victory
);

    localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(LIVES);
    localparam logic [ENEMY_W-1:0] ENEMY_INIT   = ENEMY_W'(ENEMY_COUNT);
    localparam logic [FRAME_W-1:0] RESPAWN_INIT = FRAME_W'(RESPAWN_FRAMES);
    localparam logic [FRAME_W-1:0] BLINK_INIT   = FRAME_W'(BLINK_FRAMES);

    game_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [ENEMY_W-1:0] enemies_q, enemies_d;
    logic               start_q;
    logic               start_armed_q, start_armed_d;
    logic               start_rise;

    logic play_en_q, play_en_d;
    logic tank_visible_q, tank_visible_d;
    logic eagle_visible_q, eagle_visible_d;
    logic respawn_pulse_q, respawn_pulse_d;
    logic round_start_q, round_start_d;
    logic game_over_q, game_over_d;
    logic victory_q, victory_d;

    // start_q resets to 0, so a button already held at reset release would
    // look like a rising edge. The armed flag only sets once the button has
    // been seen low, which suppresses that false edge.
    always_comb begin
        start_armed_d = start_armed_q | ~start_btn;
        start_rise    = start_btn & ~start_q & start_armed_q;
    end

    always_comb begin
        state_d         = state_q;
        frame_cnt_d     = frame_cnt_q;
        lives_d         = lives_q;
        enemies_d       = enemies_q;
        round_start_d   = 1'b0;
        respawn_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d       = ST_PLAY;
                    lives_d       = LIVES_INIT;
                    enemies_d     = ENEMY_INIT;
                    round_start_d = 1'b1;
                end
            end

            ST_PLAY: begin
                if (eagle_hit) begin
                    state_d     = ST_EAGLE_FALL;
                    frame_cnt_d = BLINK_INIT;
                end else if (tank_hit) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d     = lives_q - LIVES_W'(1);
                        state_d     = ST_RESPAWN;
                        frame_cnt_d = RESPAWN_INIT;
                    end
                end else if (enemy_killed) begin
                    if (enemies_q <= ENEMY_W'(1)) begin
                        enemies_d = '0;
                        state_d   = ST_VICTORY;
                    end else begin
                        enemies_d = enemies_q - ENEMY_W'(1);
                    end
                end
            end

            ST_RESPAWN: begin
                // An event in the same cycle as a tick wins; the frame
                // count simply waits for the next tick.
                if (eagle_hit) begin
                    state_d     = ST_EAGLE_FALL;
                    frame_cnt_d = BLINK_INIT;
                end else if (enemy_killed) begin
                    if (enemies_q <= ENEMY_W'(1)) begin
                        enemies_d = '0;
                        state_d   = ST_VICTORY;
                    end else begin
                        enemies_d = enemies_q - ENEMY_W'(1);
                    end
                end else if (refresh_tick) begin
                    if (frame_cnt_q <= FRAME_W'(1)) begin
                        frame_cnt_d     = '0;
                        state_d         = ST_PLAY;
                        respawn_pulse_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRAME_W'(1);
                    end
                end
            end

            ST_EAGLE_FALL: begin
                if (refresh_tick) begin
                    if (frame_cnt_q <= FRAME_W'(1)) begin
                        frame_cnt_d = '0;
                        state_d     = ST_GAME_OVER;
                    end else begin
                        frame_cnt_d = frame_cnt_q - FRAME_W'(1);
                    end
                end
            end

            ST_GAME_OVER, ST_VICTORY: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so that the registered
        // copies line up with state_o in the same cycle.
        play_en_d      = (state_d == ST_PLAY);
        tank_visible_d = (state_d == ST_PLAY) || (state_d == ST_EAGLE_FALL);
        if (state_d == ST_EAGLE_FALL) begin
            eagle_visible_d = frame_cnt_d[BLINK_BIT];
        end else begin
            eagle_visible_d = (state_d != ST_GAME_OVER);
        end
        game_over_d = (state_d == ST_GAME_OVER);
        victory_d   = (state_d == ST_VICTORY);
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            frame_cnt_q     <= '0;
            lives_q         <= '0;
            enemies_q       <= '0;
            start_q         <= 1'b0;
            start_armed_q   <= 1'b0;
            play_en_q       <= 1'b0;
            tank_visible_q  <= 1'b0;
            eagle_visible_q <= 1'b1;
            respawn_pulse_q <= 1'b0;
            round_start_q   <= 1'b0;
            game_over_q     <= 1'b0;
            victory_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_cnt_q     <= frame_cnt_d;
            lives_q         <= lives_d;
            enemies_q       <= enemies_d;
            start_q         <= start_btn;
            start_armed_q   <= start_armed_d;
            play_en_q       <= play_en_d;
            tank_visible_q  <= tank_visible_d;
            eagle_visible_q <= eagle_visible_d;
            respawn_pulse_q <= respawn_pulse_d;
            round_start_q   <= round_start_d;
            game_over_q     <= game_over_d;
            victory_q       <= victory_d;
        end
    end

    assign state_o       = state_q;
    assign play_en       = play_en_q;
    assign tank_visible  = tank_visible_q;
    assign eagle_visible = eagle_visible_q;
    assign respawn_pulse = respawn_pulse_q;
    assign round_start   = round_start_q;
    assign lives         = lives_q;
    assign enemies_left  = enemies_q;
    assign game_over     = game_over_q;
    assign victory       = victory_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       refresh_tick, start_btn, eagle_hit, tank_hit, enemy_killed;

    logic [2:0] state_o, state_o2;
    logic       play_en, tank_visible, eagle_visible, respawn_pulse, round_start;
    logic [1:0] lives, lives2;
    logic [7:0] enemies_left, enemies_left2;
    logic       game_over, victory;
    logic       play_en2, tank_visible2, eagle_visible2, respawn_pulse2, round_start2;
    logic       game_over2, victory2;

    always #5 clk = ~clk;

    game_flow_ctrl dut (
        .clk_50MHz(clk), .reset(reset), .refresh_tick(refresh_tick),
        .start_btn(start_btn), .eagle_hit(eagle_hit), .tank_hit(tank_hit),
        .enemy_killed(enemy_killed), .state_o(state_o), .play_en(play_en),
        .tank_visible(tank_visible), .eagle_visible(eagle_visible),
        .respawn_pulse(respawn_pulse), .round_start(round_start),
        .lives(lives), .enemies_left(enemies_left),
        .game_over(game_over), .victory(victory)
    );

    game_flow_ctrl #(.ENEMY_COUNT(2)) dut2 (
        .clk_50MHz(clk), .reset(reset), .refresh_tick(refresh_tick),
        .start_btn(start_btn), .eagle_hit(eagle_hit), .tank_hit(tank_hit),
        .enemy_killed(enemy_killed), .state_o(state_o2), .play_en(play_en2),
        .tank_visible(tank_visible2), .eagle_visible(eagle_visible2),
        .respawn_pulse(respawn_pulse2), .round_start(round_start2),
        .lives(lives2), .enemies_left(enemies_left2),
        .game_over(game_over2), .victory(victory2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the default-parameter instance.
    localparam int P_LIVES = 3, P_ENEMY = 20, P_RESP = 60, P_BLINK = 90, P_BIT = 3;
    int m_mode, m_lives, m_enemies, m_frames;
    bit m_prev_btn, m_seen_low, m_round_pulse, m_resp_pulse;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lives = 0; m_enemies = 0; m_frames = 0;
        m_prev_btn = 0; m_seen_low = 0; m_round_pulse = 0; m_resp_pulse = 0;
    endtask

    // Handles an enemy kill; returns 1 when the round is won.
    function automatic bit model_kill();
        if (m_enemies <= 1) begin
            m_enemies = 0;
            return 1'b1;
        end
        m_enemies = m_enemies - 1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit s, input bit e, input bit t, input bit k, input bit tk);
        bit pressed;
        pressed = s && !m_prev_btn && m_seen_low;
        m_seen_low = m_seen_low || !s;
        m_prev_btn = s;
        m_round_pulse = 0;
        m_resp_pulse = 0;
        if (m_mode == 0) begin
            if (pressed) begin
                m_mode = 1; m_lives = P_LIVES; m_enemies = P_ENEMY; m_round_pulse = 1;
            end
        end else if (m_mode == 1) begin
            if (e) begin
                m_mode = 3; m_frames = P_BLINK;
            end else if (t) begin
                if (m_lives <= 1) begin m_lives = 0; m_mode = 4; end
                else begin m_lives--; m_mode = 2; m_frames = P_RESP; end
            end else if (k) begin
                if (model_kill()) m_mode = 5;
            end
        end else if (m_mode == 2) begin
            if (e) begin
                m_mode = 3; m_frames = P_BLINK;
            end else if (k) begin
                if (model_kill()) m_mode = 5;
            end else if (tk) begin
                m_frames = (m_frames > 0) ? m_frames - 1 : 0;
                if (m_frames == 0) begin m_mode = 1; m_resp_pulse = 1; end
            end
        end else if (m_mode == 3) begin
            if (tk) begin
                m_frames = (m_frames > 0) ? m_frames - 1 : 0;
                if (m_frames == 0) m_mode = 4;
            end
        end else begin
            if (pressed) m_mode = 0;
        end
    endtask

    task automatic check_model();
        int ev;
        if (m_mode == 3) ev = (m_frames / (1 << P_BIT)) % 2;
        else ev = (m_mode == 4) ? 0 : 1;
        cmp("state_o", state_o, m_mode);
        cmp("lives", lives, m_lives);
        cmp("enemies_left", enemies_left, m_enemies);
        cmp("play_en", play_en, (m_mode == 1) ? 1 : 0);
        cmp("tank_visible", tank_visible, (m_mode == 1 || m_mode == 3) ? 1 : 0);
        cmp("eagle_visible", eagle_visible, ev);
        cmp("round_start", round_start, m_round_pulse);
        cmp("respawn_pulse", respawn_pulse, m_resp_pulse);
        cmp("game_over", game_over, (m_mode == 4) ? 1 : 0);
        cmp("victory", victory, (m_mode == 5) ? 1 : 0);
    endtask

    task automatic step(input bit s, input bit e, input bit t, input bit k, input bit tk);
        start_btn = s; eagle_hit = e; tank_hit = t; enemy_killed = k; refresh_tick = tk;
        model_step(s, e, t, k, tk);
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Asserts reset away from the clock edge and checks it acts at once.
    task automatic do_reset();
        #3 reset = 1'b1;
        model_reset();
        #1;
        cmp("async_reset_state", state_o, 0);
        cmp("async_reset_play_en", play_en, 0);
        cmp("async_reset_eagle_vis", eagle_visible, 1);
        check_model();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    typedef struct {
        bit s, e, t, k, tk;
        int st, lv, en, pe, tv, ev, rs, rp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        reset = 1'b1;
        start_btn = 0; eagle_hit = 0; tank_hit = 0; enemy_killed = 0; refresh_tick = 0;
        model_reset();

        tbl[0] = '{0,0,0,0,0, 0,0, 0,0,0,1,0,0};
        tbl[1] = '{1,0,0,0,0, 1,3,20,1,1,1,1,0};
        tbl[2] = '{1,0,0,0,1, 1,3,20,1,1,1,0,0};
        tbl[3] = '{1,0,0,1,0, 1,3,19,1,1,1,0,0};
        tbl[4] = '{0,0,1,0,0, 2,2,19,0,0,1,0,0};
        tbl[5] = '{0,0,0,1,1, 2,2,18,0,0,1,0,0};
        tbl[6] = '{0,0,1,0,0, 2,2,18,0,0,1,0,0};
        tbl[7] = '{0,0,0,0,1, 2,2,18,0,0,1,0,0};

        @(posedge clk);
        #1;
        check_model();
        cmp("reset_lives", lives, 0);
        cmp("reset_tank_vis", tank_visible, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Opening of a round, fixed vectors.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].s, tbl[i].e, tbl[i].t, tbl[i].k, tbl[i].tk);
            cmp("tbl_state", state_o, tbl[i].st);
            cmp("tbl_lives", lives, tbl[i].lv);
            cmp("tbl_enemies", enemies_left, tbl[i].en);
            cmp("tbl_play_en", play_en, tbl[i].pe);
            cmp("tbl_tank_vis", tank_visible, tbl[i].tv);
            cmp("tbl_eagle_vis", eagle_visible, tbl[i].ev);
            cmp("tbl_round_start", round_start, tbl[i].rs);
            cmp("tbl_respawn", respawn_pulse, tbl[i].rp);
        end

        // One tick already consumed by tbl[7]; 59 more end the respawn.
        for (int i = 0; i < 58; i++) begin
            step(0,0,0,0,1);
            cmp("resp_wait_state", state_o, 2);
        end
        step(0,0,0,0,1);
        cmp("resp_end_state", state_o, 1);
        cmp("resp_end_pulse", respawn_pulse, 1);
        step(0,0,0,0,0);
        cmp("resp_pulse_clear", respawn_pulse, 0);

        step(0,0,1,0,0);
        cmp("second_hit_lives", lives, 1);
        for (int i = 0; i < 59; i++) step(0,0,0,0,1);
        cmp("resp2_state_before", state_o, 2);
        step(0,0,0,0,1);
        cmp("resp2_state_after", state_o, 1);

        step(0,0,1,0,0);
        cmp("last_hit_state", state_o, 4);
        cmp("last_hit_lives", lives, 0);
        cmp("last_hit_game_over", game_over, 1);
        cmp("last_hit_play_en", play_en, 0);

        step(1,0,0,0,0);
        cmp("gover_to_idle", state_o, 0);
        step(0,0,0,0,0);
        step(1,0,0,0,0);
        cmp("restart_lives", lives, 3);

        // All three events at once: eagle wins, counters untouched.
        step(0,1,1,1,0);
        cmp("triple_state", state_o, 3);
        cmp("triple_lives", lives, 3);
        cmp("triple_enemies", enemies_left, 20);
        for (int k = 1; k < 90; k++) begin
            step(0,1,0,0,1);
            cmp("blink_state", state_o, 3);
            cmp("blink_bit", eagle_visible, ((90 - k) >> 3) & 1);
        end
        step(0,1,0,0,1);
        cmp("blink_end_state", state_o, 4);
        cmp("blink_end_eagle", eagle_visible, 0);

        // eagle_hit still high: acted on in the very first PLAY cycle.
        step(1,1,0,0,0);
        step(0,1,0,0,0);
        step(1,1,0,0,0);
        cmp("eagle_level_play", state_o, 1);
        step(0,1,0,0,0);
        cmp("eagle_level_fall", state_o, 3);

        // Reset mid-respawn with frame count 30, button held through release.
        eagle_hit = 0;
        do_reset();
        step(0,0,0,0,0);
        step(1,0,0,0,0);
        step(0,0,1,0,0);
        for (int i = 0; i < 30; i++) step(0,0,0,0,1);
        cmp("pre_reset_state", state_o, 2);
        start_btn = 1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1,0,0,0,0);
            cmp("held_btn_state", state_o, 0);
        end
        step(0,0,0,0,0);
        step(1,0,0,0,0);
        cmp("rearmed_state", state_o, 1);

        // Small enemy count instance reaching victory.
        do_reset();
        step(0,0,0,0,0);
        step(1,0,0,0,0);
        cmp("v_state_play", state_o2, 1);
        cmp("v_enemies_init", enemies_left2, 2);
        step(0,0,0,1,0);
        cmp("v_enemies_one", enemies_left2, 1);
        step(0,0,0,1,0);
        cmp("v_enemies_zero", enemies_left2, 0);
        cmp("v_state", state_o2, 5);
        cmp("v_flag", victory2, 1);
        cmp("v_play_en", play_en2, 0);
        step(0,0,0,0,0);
        step(1,0,0,0,0);
        cmp("v_to_idle", state_o2, 0);

        // Random episodes against the model.
        for (int ep = 0; ep < 10; ep++) begin
            bit s, e;
            s = 0; e = 0;
            eagle_hit = 0;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 14) == 0) s = ~s;
                if (!e && $urandom_range(0, 299) == 0) e = 1;
                step(s, e,
                     ($urandom_range(0, 24) == 0),
                     ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 1) == 1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
